// File: rtl/sd_tx_nibble_fifo.sv
// Word-in, nibble-out transmit FIFO feeding the SD DAT bus.
// The head word is presented MSB nibble first and retired after its 8th nibble is popped.
module sd_tx_nibble_fifo #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       d,
  input  logic              wr,
  output logic              full,
  output logic [3:0]        q,
  input  logic              rd,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              ovf,
  output logic              unf
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned NIB_W = 3;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [CNT_W-1:0]  wcnt;
  logic [NIB_W-1:0]  nidx;

  logic        push;
  logic        pop;
  logic        retire;
  logic [31:0] head;
  logic [4:0]  shamt;

  assign empty  = (wcnt == CNT_W'(0));
  assign full   = (wcnt == CNT_W'(DEPTH));
  assign level  = wcnt;

  assign push   = wr && !full;
  assign pop    = rd && !empty;
  assign retire = pop && (nidx == NIB_W'(7));

  // First-word-fall-through view; nibble 0 is bits [31:28], so shift by (7-nidx)*4.
  assign head  = mem[rptr];
  assign shamt = {~nidx, 2'b00};
  assign q     = empty ? 4'h0 : 4'(head >> shamt);

  // Storage is not reset; occupancy is tracked by wcnt alone.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wptr] <= d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      wcnt <= '0;
      nidx <= '0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + ADDR_W'(1);
      end
      if (pop) begin
        nidx <= nidx + NIB_W'(1);
      end
      if (retire) begin
        rptr <= rptr + ADDR_W'(1);
      end
      // A write and a retiring pop in the same cycle leave the count unchanged.
      case ({push, retire})
        2'b10:   wcnt <= wcnt + CNT_W'(1);
        2'b01:   wcnt <= wcnt - CNT_W'(1);
        default: wcnt <= wcnt;
      endcase
      if (wr && full) begin
        ovf <= 1'b1;
      end
      if (rd && empty) begin
        unf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sd_tx_nibble_fifo.sv
// Bench for sd_tx_nibble_fifo: directed corner cases plus random traffic
// checked against a queue-of-words reference model.
module tb_sd_tx_nibble_fifo;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       d;
  logic              wr;
  logic              full;
  logic [3:0]        q;
  logic              rd;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              ovf;
  logic              unf;

  sd_tx_nibble_fifo #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .d     (d),
    .wr    (wr),
    .full  (full),
    .q     (q),
    .rd    (rd),
    .empty (empty),
    .level (level),
    .ovf   (ovf),
    .unf   (unf)
  );

  always #5 clk = ~clk;

  // Reference model: words held, and how many nibbles of the head word are already consumed.
  logic [31:0] mq[$];
  int          mn;
  bit          movf;
  bit          munf;

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_q();
    logic [31:0] w;
    if (mq.size() == 0) return 4'h0;
    w = mq[0];
    return 4'(w >> (28 - 4 * mn));
  endfunction

  task automatic check_all();
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full",  32'(full),  32'(mq.size() == DEPTH));
    chk("level", 32'(level), 32'(mq.size()));
    chk("q",     32'(q),     32'(model_q()));
    chk("ovf",   32'(ovf),   32'(movf));
    chk("unf",   32'(unf),   32'(munf));
  endtask

  // Apply one cycle of inputs, advance the model with the pre-edge state, then compare.
  task automatic step(input bit w, input logic [31:0] dv, input bit r, input bit rs);
    bit f;
    bit e;
    wr  = w;
    d   = dv;
    rd  = r;
    rst = rs;
    @(posedge clk);
    if (rs) begin
      mq.delete();
      mn   = 0;
      movf = 1'b0;
      munf = 1'b0;
    end else begin
      f = (mq.size() == DEPTH);
      e = (mq.size() == 0);
      if (w && f) movf = 1'b1;
      if (r && e) munf = 1'b1;
      if (r && !e) begin
        mn++;
        if (mn == 8) begin
          mq.delete(0);
          mn = 0;
        end
      end
      if (w && !f) mq.push_back(dv);
    end
    #1;
    check_all();
    wr  = 1'b0;
    rd  = 1'b0;
    rst = 1'b0;
  endtask

  logic [3:0]  seq32 [8];
  logic [31:0] written[$];
  logic [31:0] asm_word;
  int          nib_cnt;
  int          widx;
  logic [31:0] rw;

  initial begin
    n_vec = 0;
    n_err = 0;
    mn    = 0;
    movf  = 1'b0;
    munf  = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    rst   = 1'b1;
    d     = '0;
    seq32 = '{4'ha, 4'hb, 4'hc, 4'hd, 4'he, 4'hf, 4'hd, 4'hc};

    // Reset state
    @(negedge clk);
    step(0, 32'h0, 0, 1);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_level", 32'(level), 32'd0);

    // One word drained nibble by nibble
    step(1, 32'hABCDEFDC, 0, 0);
    chk("w1_level", 32'(level), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("w1_seq", 32'(q), 32'(seq32[i]));
      step(0, 32'h0, 1, 0);
    end
    chk("w1_empty", 32'(empty), 32'd1);
    chk("w1_level0", 32'(level), 32'd0);

    // Fill, overflow write dropped, then drain
    step(0, 32'h0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 32'h1000_0001 * (i + 1), 0, 0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd4);
    step(1, 32'h12345678, 0, 0);
    chk("fill_ovf", 32'(ovf), 32'd1);
    for (int i = 0; i < 32; i++) step(0, 32'h0, 1, 0);
    chk("fill_drained", 32'(empty), 32'd1);

    // Write while full on the retiring pop is still dropped
    step(0, 32'h0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, $urandom, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 32'h0, 1, 0);
    step(1, 32'hFEDCBA98, 1, 0);
    chk("fullret_ovf", 32'(ovf), 32'd1);
    chk("fullret_level", 32'(level), 32'd3);

    // Single word, last nibble popped while a new word arrives
    step(0, 32'h0, 0, 1);
    step(1, 32'h13579BDF, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 32'h0, 1, 0);
    step(1, 32'h9ACE0246, 1, 0);
    chk("swap_level", 32'(level), 32'd1);
    chk("swap_q", 32'(q), 32'h9);

    // Pop while empty, then reset mid-word
    step(0, 32'h0, 0, 1);
    step(0, 32'h0, 1, 0);
    chk("unf_flag", 32'(unf), 32'd1);
    chk("unf_q", 32'(q), 32'h0);
    chk("unf_level", 32'(level), 32'd0);
    step(1, 32'h2468ACE1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 1, 0);
    step(1, 32'h55555555, 1, 1);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_unf", 32'(unf), 32'd0);
    step(1, 32'h0F0F0F0F, 0, 0);
    chk("postrst_level", 32'(level), 32'd1);
    chk("postrst_q", 32'(q), 32'h0);

    // Streaming: one word per 8 cycles, continuous reads, several pointer wraps
    step(0, 32'h0, 0, 1);
    written.delete();
    nib_cnt  = 0;
    widx     = 0;
    asm_word = '0;
    for (int k = 0; k <= 128; k++) begin
      bit do_w;
      bit do_r;
      do_w = (k % 8 == 0) && (k < 128);
      do_r = (k >= 1);
      if (do_r) begin
        asm_word = {asm_word[27:0], q};
        nib_cnt++;
        if (nib_cnt == 8) begin
          chk("stream", asm_word, (widx < written.size()) ? written[widx] : 32'hx);
          widx++;
          nib_cnt = 0;
        end
      end
      rw = $urandom;
      if (do_w) written.push_back(rw);
      step(do_w, rw, do_r, 0);
    end
    chk("stream_words", 32'(widx), 32'd16);
    chk("stream_ovf", 32'(ovf), 32'd0);
    chk("stream_unf", 32'(unf), 32'd0);

    // Random traffic
    step(0, 32'h0, 0, 1);
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 99) < 30), $urandom,
           ($urandom_range(0, 99) < 85), ($urandom_range(0, 199) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sd_tx_nibble_fifo.md
SD_TX_NIBBLE_FIFO -- requirements
Module: sd_tx_nibble_fifo

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 2, meaning log2 of the word-storage depth.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of 32-bit word slots (2**ADDR_W).
REQ-003 Port clk, input, 1: single clock; all logic SHALL be on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port d, input, 32: host write word.
REQ-006 Port wr, input, 1: write strobe; pushes d when not full.
REQ-007 Port full, output, 1: high when DEPTH words are held.
REQ-008 Port q, output, 4: current head nibble toward the SD DAT bus.
REQ-009 Port rd, input, 1: nibble pop strobe.
REQ-010 Port empty, output, 1: high when no nibble is available.
REQ-011 Port level, output, ADDR_W+1: count of words held, including a partially consumed head word.
REQ-012 Port ovf, output, 1: sticky flag for a write attempted while full.
REQ-013 Port unf, output, 1: sticky flag for a pop attempted while empty.

Function
REQ-014 Storage SHALL be DEPTH x 32 bits, with a write pointer and a read pointer each ADDR_W bits wide that wrap modulo DEPTH.
REQ-015 A word count wcnt (0..DEPTH) and a nibble index nidx (3 bits, 0..7) SHALL form the state.
REQ-016 A write with wr=1 and full=0 SHALL store d at the write pointer, increment the write pointer, and increment wcnt at the clock edge.
REQ-017 A write with wr=1 and full=1 SHALL be dropped and SHALL set ovf; the memory and pointers SHALL be unchanged.
REQ-018 q SHALL be a combinational first-word-fall-through view: mem[rptr] nibble selected by nidx, MSB first.
  - nidx 0 selects [31:28]; nidx 7 selects [3:0].
REQ-019 A pop with rd=1 and empty=0 SHALL increment nidx.
  - When nidx=7, nidx SHALL wrap to 0, rptr SHALL increment, and wcnt SHALL decrement (head word retired).
REQ-020 A pop with rd=1 and empty=1 SHALL be ignored and SHALL set unf.
REQ-021 The flags SHALL be defined as: empty = (wcnt==0); full = (wcnt==DEPTH); level = wcnt.
REQ-022 Latency: a word written at edge N SHALL give empty=0 and valid q after edge N, so it can be popped at edge N+1.
REQ-023 On a simultaneous accepted write and word-retiring pop in one cycle, wcnt SHALL be unchanged and both pointers SHALL advance.
REQ-024 On a simultaneous write while full and a retiring pop, the write SHALL still be dropped (full is sampled before the edge) and ovf SHALL be set.
REQ-025 On a simultaneous accepted write and a non-retiring pop, wcnt SHALL increment and nidx SHALL increment.
REQ-026 When empty=1, q SHALL be 4'h0 (it is not required to reflect stale memory).
REQ-027 A partially consumed head word SHALL occupy its slot until its 8th nibble is popped.
REQ-028 ovf and unf SHALL hold until reset.

Reset
REQ-029 With rst=1 at an edge, the block SHALL clear wptr, rptr, wcnt, nidx, ovf and unf, giving empty=1, full=0, level=0 and q=4'h0.
  - Memory contents are not reset.
REQ-030 rst SHALL take priority over wr and rd in the same cycle; data held mid-word SHALL be discarded.
REQ-031 After reset release, the first write SHALL be accepted in the next cycle.

Verification
REQ-032 Bench SHALL cover: write 32'hABCDEFDC, then rd held for 8 cycles -> q sequence a,b,c,d,e,f,d,c; then empty=1, level 0->1->0.
REQ-033 Bench SHALL cover: 4 writes with no reads -> full=1, level=4; a 5th write of 32'h12345678 -> dropped, ovf=1, and the later readout omits it.
REQ-034 Bench SHALL cover: full FIFO; on the 8th pop of the head word, assert wr with 32'hFEDCBA98 -> write dropped, ovf=1, level=3.
REQ-035 Bench SHALL cover: level=1, nidx=7, wr and rd together -> level stays 1, and the next q is the new word's [31:28].
REQ-036 Bench SHALL cover: rd while empty -> unf=1, q=0, state unchanged; and rst mid-word (nidx=3) -> empty=1, level=0, flags cleared next cycle.
REQ-037 Bench SHALL cover: continuous 1-word/8-cycle writes with continuous reads across 3 pointer wraps -> a nibble stream identical to the written data, and ovf=0, unf=0.
